// File: rtl/reset_if.sv
// Potential datapath bundle between the adder stage, the reset stage and
// the neuron state memory. The master side drives operands and reads back
// the registered potential; the slave side is the reset stage itself.
interface reset_if;
  logic [31:0] adder_potential;
  logic        spiked;
  logic [31:0] v_threshold;
  logic [31:0] potential_to_mem;

  modport master (
    output adder_potential,
    output spiked,
    output v_threshold,
    input  potential_to_mem
  );

  modport slave (
    input  adder_potential,
    input  spiked,
    input  v_threshold,
    output potential_to_mem
  );
endinterface

// File: rtl/reset.sv
// Membrane-potential reset stage. When the neuron spikes, the firing
// threshold is subtracted from the accumulated binary32 potential (reset by
// subtraction); otherwise the potential passes through bit-exact. The result
// is registered once before being written back to neuron memory.
module reset (
  input  logic   CLK,
  input  logic   RESET_N,
  reset_if.slave bus
);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        aSign, bSign, aZero, bZero, aInf, bInf, aNan, bNan;
  logic [7:0]  aExp, bExp;
  logic [23:0] aSig, bSig;
  logic        aBig;
  logic        xSign, ySign, effSub;
  logic [7:0]  xExp, yExp, expDiff;
  logic [23:0] xSig, ySig;
  logic [4:0]  shAmt;
  logic [26:0] yExt, yAligned;
  logic [27:0] sumRaw;
  logic [26:0] norm;
  logic [4:0]  lz;
  logic [9:0]  normExp, finalExp;
  logic        underflow, roundUp;
  logic [24:0] rounded;
  logic [22:0] frac;
  logic [31:0] diff;
  logic [31:0] potential_d, potential_q;

  // Position of the leading one relative to the hidden-bit slot (bit 26).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // Binary32 subtraction adder_potential - v_threshold, done as an addition
  // with the threshold sign flipped. Subnormal operands are read as zero.
  always_comb begin
    aExp  = bus.adder_potential[30:23];
    bExp  = bus.v_threshold[30:23];
    aSign = bus.adder_potential[31];
    bSign = ~bus.v_threshold[31];
    aZero = (aExp == 8'h00);
    bZero = (bExp == 8'h00);
    aInf  = (aExp == 8'hFF) && (bus.adder_potential[22:0] == 23'd0);
    bInf  = (bExp == 8'hFF) && (bus.v_threshold[22:0] == 23'd0);
    aNan  = (aExp == 8'hFF) && (bus.adder_potential[22:0] != 23'd0);
    bNan  = (bExp == 8'hFF) && (bus.v_threshold[22:0] != 23'd0);
    aSig  = aZero ? 24'd0 : {1'b1, bus.adder_potential[22:0]};
    bSig  = bZero ? 24'd0 : {1'b1, bus.v_threshold[22:0]};

    // The larger magnitude becomes x so the difference never goes negative
    // and its sign alone decides the result sign.
    aBig  = {aExp, aSig} >= {bExp, bSig};
    xSign = aBig ? aSign : bSign;
    xExp  = aBig ? aExp  : bExp;
    xSig  = aBig ? aSig  : bSig;
    ySign = aBig ? bSign : aSign;
    yExp  = aBig ? bExp  : aExp;
    ySig  = aBig ? bSig  : bSig ^ bSig ^ aSig;
    effSub  = xSign ^ ySign;
    expDiff = xExp - yExp;

    // Align y with guard/round bits and fold every shifted-out bit into
    // the sticky position.
    yExt  = {ySig, 3'b000};
    shAmt = expDiff[4:0];
    if (expDiff > 8'd26) begin
      yAligned = {26'd0, |ySig};
    end else begin
      yAligned    = yExt >> shAmt;
      yAligned[0] = yAligned[0] | (|(yExt & ~({27{1'b1}} << shAmt)));
    end

    sumRaw = effSub ? ({1'b0, xSig, 3'b000} - {1'b0, yAligned})
                    : ({1'b0, xSig, 3'b000} + {1'b0, yAligned});

    // Normalise: one right shift on carry-out, otherwise left shift out
    // the leading zeros left behind by cancellation.
    lz        = lzc27(sumRaw[26:0]);
    underflow = 1'b0;
    if (sumRaw[27]) begin
      norm    = {sumRaw[27:2], sumRaw[1] | sumRaw[0]};
      normExp = {2'b00, xExp} + 10'd1;
    end else begin
      norm      = sumRaw[26:0] << lz;
      normExp   = {2'b00, xExp} - {5'd0, lz};
      underflow = ({3'b000, lz} >= xExp);
    end

    // Round to nearest, ties to even; a mantissa carry bumps the exponent.
    roundUp  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[26:3]} + {24'd0, roundUp};
    frac     = rounded[24] ? rounded[23:1] : rounded[22:0];
    finalExp = normExp + {9'd0, rounded[24]};

    if (aNan || bNan) begin
      diff = QNAN;
    end else if (aInf && bInf) begin
      diff = (bus.adder_potential[31] == bus.v_threshold[31]) ? QNAN
             : {bus.adder_potential[31], 8'hFF, 23'd0};
    end else if (aInf) begin
      diff = {bus.adder_potential[31], 8'hFF, 23'd0};
    end else if (bInf) begin
      diff = {~bus.v_threshold[31], 8'hFF, 23'd0};
    end else if ((sumRaw == 28'd0) || underflow) begin
      diff = 32'h00000000;
    end else if (finalExp >= 10'd255) begin
      diff = {xSign, 8'hFF, 23'd0};
    end else begin
      diff = {xSign, finalExp[7:0], frac};
    end
  end

  assign potential_d = bus.spiked ? diff : bus.adder_potential;

  // Output register; an asserted reset clears it immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) potential_q <= 32'h00000000;
    else          potential_q <= potential_d;
  end

  assign bus.potential_to_mem = potential_q;
endmodule

// File: tb/tb_reset.sv
// Directed bench for the membrane-potential reset stage: hand-computed
// binary32 subtraction results, pass-through cases and async reset.
module tb_reset;
  logic CLK;
  logic RESET_N;
  int   checks;
  int   errors;

  reset_if bus ();

  reset dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic setInputs(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.adder_potential = a;
    bus.v_threshold     = b;
    bus.spiked          = s;
  endtask

  // Drive one operand set, let one rising edge capture it, sample 1 ns later.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    setInputs(a, b, s);
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expected);
    checks++;
    assert (bus.potential_to_mem === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, bus.potential_to_mem, expected);
    end
  endtask

  task automatic runCase(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] expected);
    applyStimulus(a, b, s);
    checkOutput(tag, expected);
  endtask

  // Linear directed sequence.
  initial begin
    checks  = 0;
    errors  = 0;
    RESET_N = 1'b0;
    setInputs(32'h40F00000, 32'h40A00000, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_state", 32'h00000000);
    @(negedge CLK);
    RESET_N = 1'b1;

    runCase("equal_spike",   32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000);
    runCase("no_spike",      32'h40A00000, 32'h40A00000, 1'b0, 32'h40A00000);
    runCase("pos_remainder", 32'h40F00000, 32'h40A00000, 1'b1, 32'h40200000);
    runCase("neg_result",    32'h40000000, 32'h40A00000, 1'b1, 32'hC0400000);
    runCase("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    runCase("ninf_minus_ninf", 32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000);
    runCase("nan_a",         32'h7FC12345, 32'h3F800000, 1'b1, 32'h7FC00000);
    runCase("nan_b",         32'h3F800000, 32'hFF800001, 1'b1, 32'h7FC00000);
    runCase("inf_minus_ninf", 32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000);
    runCase("fin_minus_ninf", 32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000);
    runCase("fin_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);
    runCase("ninf_minus_fin", 32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000);
    runCase("overflow",      32'h7F7FFFFF, 32'hFF7FFFFF, 1'b1, 32'h7F800000);
    runCase("neg_overflow",  32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000);
    runCase("tie_even_down", 32'h3F800000, 32'hB3800000, 1'b1, 32'h3F800000);
    runCase("tie_even_up",   32'h3F800001, 32'hB3800000, 1'b1, 32'h3F800002);
    runCase("sticky_round",  32'h3F800000, 32'h33000001, 1'b1, 32'h3F7FFFFF);
    runCase("sub_a_zero",    32'h00000001, 32'h3F800000, 1'b1, 32'hBF800000);
    runCase("sub_b_zero",    32'h3F800000, 32'h00400000, 1'b1, 32'h3F800000);
    runCase("flush_result",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000);
    runCase("negzero_diff",  32'h80000000, 32'h00000000, 1'b1, 32'h00000000);
    runCase("pass_nan",      32'h7FC12345, 32'h40A00000, 1'b0, 32'h7FC12345);
    runCase("pass_subnorm",  32'h00000001, 32'h40A00000, 1'b0, 32'h00000001);
    runCase("pass_neg_inf",  32'hFF800000, 32'h40A00000, 1'b0, 32'hFF800000);

    // Reset mid-stream: load a nonzero value, then pull reset between edges.
    runCase("pre_reset",     32'h40F00000, 32'h40A00000, 1'b1, 32'h40200000);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("async_clear", 32'h00000000);
    setInputs(32'h40A00000, 32'h3F800000, 1'b1);
    @(posedge CLK);
    #1;
    checkOutput("held_in_reset", 32'h00000000);
    @(negedge CLK);
    RESET_N = 1'b1;
    runCase("after_release", 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000);
    runCase("back_to_back",  32'h41200000, 32'h40A00000, 1'b0, 32'h41200000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
